// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch front end. Owns the fetch PC, issues word-addressed reads
// to instruction memory (one-cycle read latency) and buffers the returned
// words, each tagged with its PC, in a DEPTH-entry FIFO. The FIFO feeds decode
// through a valid/ready handshake. A redirect flushes everything that is
// buffered or in flight and restarts fetch at a new PC.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk             clock, all logic on posedge
//   rst             synchronous active-low reset
//   mem_addr        word address of the read request (equals fetch PC)
//   mem_rd_en       read request issued this cycle
//   mem_rd_data     read data for the request issued in the previous cycle
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     restart address
//   inst_valid      FIFO head valid
//   inst_ready      decode accepts the head
//   inst_data       head instruction (0 when inst_valid = 0)
//   inst_pc         head PC (0 when inst_valid = 0)
//
// Optional build macro IFQ_PERF_EN adds:
//   perf_fetch_cnt  number of FIFO pushes (wraps)
//   perf_stall_cnt  RUN cycles with no issue and no redirect (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CW1 = CW + 1;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q;
  // Cleared by reset; lets BOOT be the first cycle after the block has
  // actually left reset rather than the cycle in which rst is released.
  logic          armed_q;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;

  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW1-1:0] credit;

  // Head of FIFO drives decode directly from registered storage.
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;

  assign pop  = inst_valid & inst_ready;
  // A response arriving during a redirect belongs to the old stream.
  assign push = inflight_q & ~redirect_valid;

  // Credit check counts buffered entries plus the one response still on its
  // way, minus the entry leaving this cycle, so the FIFO can never overflow
  // while still sustaining one fetch per cycle.
  assign credit = CW1'(count_q) + CW1'(inflight_q) - CW1'(pop);
  assign issue  = (state_q == RUN) & ~redirect_valid & (credit < CW1'(DEPTH));

  assign mem_addr  = fetch_pc_q;
  assign mem_rd_en = issue;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    fetch_pc_d = fetch_pc_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        BOOT:    if (armed_q) state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc_q <= fetch_pc_q;
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rd_data;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (push) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if ((state_q == RUN) && !issue && !redirect_valid) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// Bench for instr_fetch_queue. Memory returns addr ^ 32'hA5A5A5A5 one cycle
// after each request. A queue-based model predicts every output each cycle;
// directed checks pin reset/boot timing, backpressure, redirect, flush while
// full, PC wrap and reset in mid-stream.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFQ_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_data   (mem_rd_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc)
`ifdef IFQ_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: one-cycle latency, data derived from the requested address.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      a = mem_addr;
      @(posedge clk);
      #1;
      mem_rd_data = a ^ K;
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: phase 0 = just out of reset, 1 = BOOT, 2 = RUN.
  // ---------------------------------------------------------------------------
  bit          known = 1'b0;
  int          phase;
  logic [31:0] m_fpc;
  int          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] mq[$];
`ifdef IFQ_PERF_EN
  logic [31:0] m_fcnt;
  logic [31:0] m_scnt;
`endif

  initial begin
    bit          ev;
    int          pop;
    int          en;
    logic [31:0] nxt_pc;
    forever begin
      @(negedge clk);
      ev  = (mq.size() > 0);
      pop = (ev && inst_ready) ? 1 : 0;
      en  = ((phase == 2) && !redirect_valid && (mq.size() + m_infl - pop < DEPTH)) ? 1 : 0;
      if (known) begin
        chk("mem_addr",   mem_addr,          m_fpc);
        chk("mem_rd_en",  32'(mem_rd_en),    32'(en));
        chk("inst_valid", 32'(inst_valid),   32'(ev));
        chk("inst_pc",    inst_pc,           ev ? mq[0] : 32'h0);
        chk("inst_data",  inst_data,         ev ? (mq[0] ^ K) : 32'h0);
`ifdef IFQ_PERF_EN
        chk("perf_fetch", perf_fetch_cnt,    m_fcnt);
        chk("perf_stall", perf_stall_cnt,    m_scnt);
`endif
      end
      if (rst === 1'b0) begin
        known  = 1'b1;
        phase  = 0;
        m_fpc  = 32'h0;
        m_infl = 0;
        mq.delete();
`ifdef IFQ_PERF_EN
        m_fcnt = 32'h0;
        m_scnt = 32'h0;
`endif
      end else if (known) begin
        nxt_pc = m_fpc;
        if (pop != 0) void'(mq.pop_front());
        if (redirect_valid) begin
          mq.delete();
          nxt_pc = redirect_pc;
        end else begin
          if (m_infl != 0) begin
            mq.push_back(m_infl_pc);
`ifdef IFQ_PERF_EN
            m_fcnt = m_fcnt + 32'd1;
`endif
          end
          if (en != 0) nxt_pc = m_fpc + 32'd1;
        end
`ifdef IFQ_PERF_EN
        if ((phase == 2) && (en == 0) && !redirect_valid) m_scnt = m_scnt + 32'd1;
`endif
        m_infl_pc = m_fpc;
        m_infl    = en;
        m_fpc     = nxt_pc;
        phase     = (phase == 0) ? 1 : 2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] iss_log[$];
  logic [31:0] pop_log[$];

  // Applies inputs for one cycle just after posedge, then samples mid-cycle.
  task automatic tick(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = r;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #3;
    if (mem_rd_en) iss_log.push_back(mem_addr);
    if (inst_valid && inst_ready) pop_log.push_back(inst_pc);
  endtask

  initial begin
    logic [31:0] wrap_seq [4];
    wrap_seq[0] = 32'hFFFF_FFFE;
    wrap_seq[1] = 32'hFFFF_FFFF;
    wrap_seq[2] = 32'h0000_0000;
    wrap_seq[3] = 32'h0000_0001;

    // Reset held for three cycles
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);

    // Release, then BOOT: no issue in either cycle
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rel_rd_en", 32'(mem_rd_en), 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("boot_rd_en", 32'(mem_rd_en), 32'h0);

    // Backpressure: ten cycles of inst_ready = 0
    iss_log.delete();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      if (i == 0) begin
        chk("first_issue_en",   32'(mem_rd_en), 32'h1);
        chk("first_issue_addr", mem_addr, 32'h0);
      end
      if (i == 2) begin
        chk("first_valid", 32'(inst_valid), 32'h1);
        chk("first_pc",    inst_pc, 32'h0);
        chk("first_data",  inst_data, 32'hA5A5_A5A5);
      end
    end
    chk("bp_issue_count", 32'(iss_log.size()), 32'd4);

    // Drain with ready held high: PCs 0..7 back to back
    pop_log.delete();
    tick(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef IFQ_PERF_EN
    chk("perf_fetch_after_bp", perf_fetch_cnt, 32'd4);
    chk("perf_stall_after_bp", perf_stall_cnt, 32'd6);
`endif
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_pop_count", 32'(pop_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("drain_pc", pop_log[i], 32'(i));

    // Redirect to 0x100 while streaming
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    chk("redir_T_rd_en", 32'(mem_rd_en), 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_T1_rd_en", 32'(mem_rd_en), 32'h1);
    chk("redir_T1_addr",  mem_addr, 32'h0000_0100);
    chk("redir_T1_valid", 32'(inst_valid), 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_T2_valid", 32'(inst_valid), 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_T3_valid", 32'(inst_valid), 32'h1);
    chk("redir_T3_pc",    inst_pc, 32'h0000_0100);

    // Fill the FIFO, then pop + redirect in the same cycle
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    chk("full_redir_head_valid", 32'(inst_valid), 32'h1);
    iss_log.delete();
    pop_log.delete();
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("full_redir_empty", 32'(inst_valid), 32'h0);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_issue_count_ge4", 32'(iss_log.size() >= 4), 32'h1);
    chk("wrap_pop_count_ge4",   32'(pop_log.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < iss_log.size(); i++) chk("wrap_issue_addr", iss_log[i], wrap_seq[i]);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("wrap_pop_pc", pop_log[i], wrap_seq[i]);

    // Build occupancy 3 with one response in flight, then a one-cycle reset
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mid_rst_pre_valid", 32'(inst_valid), 32'h1);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("mid_rst_valid", 32'(inst_valid), 32'h0);
    chk("mid_rst_pc",    inst_pc, 32'h0);
    chk("mid_rst_data",  inst_data, 32'h0);
    chk("mid_rst_addr",  mem_addr, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mid_rst_boot_en", 32'(mem_rd_en), 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_en",   32'(mem_rd_en), 32'h1);
    chk("restart_addr", mem_addr, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_valid", 32'(inst_valid), 32'h1);
    chk("restart_pc",    inst_pc, 32'h0);
    chk("restart_data",  inst_data, 32'hA5A5_A5A5);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end: owns the fetch PC, issues word-addressed reads to instruction memory (single-cycle read latency), and buffers returned instructions, each tagged with its PC, in a small FIFO. The FIFO feeds decode through a valid/ready handshake. A redirect input flushes all buffered and in-flight fetches and restarts fetch at a new PC. The block sits between instruction memory and the decode stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- RESET_PC, 32'h00000000, first fetch address after reset
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset (block in reset while rst == 0 at posedge)
- mem_addr  out  32  word address of read request (word addressing: next sequential = +1)
- mem_rd_en  out  1  read request issued this cycle
- mem_rd_data  in  32  read data for the request issued in the previous cycle
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  restart address, sampled when redirect_valid = 1
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  32  head instruction; 0 when inst_valid = 0
- inst_pc  out  32  head PC; 0 when inst_valid = 0

## Operation
- State machine: BOOT -> RUN. Reset forces BOOT. BOOT lasts exactly one cycle with no issue, then RUN. No other states.
- fetch_pc register: reset value RESET_PC. mem_addr = fetch_pc combinationally.
- Issue condition (RUN, redirect_valid = 0): occ + inflight - pop < DEPTH.
  - occ = FIFO count. inflight = 1 if a read was issued last cycle. pop = inst_valid & inst_ready this cycle.
- On issue: mem_rd_en = 1 and fetch_pc <= fetch_pc + 1, modulo 2^32 (32'hFFFFFFFF wraps to 0).
- Capture: the cycle after an issue, {mem_rd_data, issued pc} is written at the FIFO tail, unless redirect_valid = 1 in that cycle, in which case the data is discarded.
- Pop: inst_valid & inst_ready advances the head. Push and pop in the same cycle are legal at any occupancy, including full. The credit rule guarantees the FIFO never overflows.
- Redirect (redirect_valid = 1 in cycle T):
  - mem_rd_en = 0 in T.
  - FIFO cleared at the end of T.
  - Response arriving in T is discarded.
  - fetch_pc <= redirect_pc.
  - A pop in T completes normally; the consumer owns that instruction.
- Redirect during BOOT: fetch_pc <= redirect_pc; the BOOT -> RUN transition is unchanged.
- Reset mid-operation: FIFO, inflight, state and fetch_pc are cleared or re-initialised at the next posedge with rst = 0. Any in-flight response is dropped.
- Reset values: mem_rd_en = 0, mem_addr = RESET_PC, inst_valid = 0, inst_data = 0, inst_pc = 0.

## Timing
- rst released (rst = 1 at posedge P): cycle P+1 is BOOT; first issue of RESET_PC is in cycle P+2; that instruction has inst_valid = 1 in P+4.
- Issue-to-output latency: 2 cycles (issue T, capture T+1, inst_valid T+2), assuming the FIFO was empty.
- Throughput: 1 instruction/cycle sustained with inst_ready held high, for any DEPTH >= 2.
- Redirect at T: first issue at redirect_pc in T+1. inst_valid = 0 in T+1 and T+2. New instruction valid in T+3.
- inst_valid, inst_data and inst_pc are registered (FIFO head). mem_rd_en is combinational from registered state plus inst_ready and redirect_valid.

## Configuration
- IFQ_PERF_EN defined:
  - Adds output perf_fetch_cnt (32) and output perf_stall_cnt (32). Both reset to 0 and wrap modulo 2^32.
  - perf_fetch_cnt increments on every push.
  - perf_stall_cnt increments on every RUN cycle with no issue and redirect_valid = 0.
- IFQ_PERF_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset/boot:
  - Stimulus: hold rst = 0 for 3 cycles, release; memory returns data = addr ^ 32'hA5A5A5A5.
  - Required: mem_rd_en = 0 and inst_valid = 0 during reset and BOOT; mem_addr sequence 0, 1, 2, ...; first inst_pc = 0 with inst_data = 32'hA5A5A5A5, four cycles after release.
- Backpressure (DEPTH = 4):
  - Stimulus: inst_ready = 0 for 10 cycles.
  - Required: exactly 4 issues, then mem_rd_en = 0; occupancy 4. With inst_ready = 1 afterwards, inst_pc sequence 0..3 followed by 4, 5, ... with no gap or duplicate.
- Redirect:
  - Stimulus: in steady streaming, redirect_valid = 1 with redirect_pc = 32'h100 in cycle T.
  - Required: no issue in T; mem_addr = 32'h100 with mem_rd_en = 1 in T+1; inst_valid = 0 in T+1 and T+2; inst_pc = 32'h100 in T+3; no stale PC ever appears after T.
- Simultaneous pop + redirect + full:
  - Stimulus: FIFO full, inst_ready = 1, redirect_valid = 1 in the same cycle.
  - Required: the head is transferred once; the FIFO is empty next cycle.
- Wrap:
  - Stimulus: redirect_pc = 32'hFFFFFFFE.
  - Required: issued addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; inst_pc follows the same sequence.
- Reset mid-stream:
  - Stimulus: rst = 0 for one cycle while inflight = 1 and occupancy = 3.
  - Required: all outputs reach their reset values next cycle; after release, fetch restarts at RESET_PC and the dropped response is never output.
- IFQ_PERF_EN build:
  - Required: after the backpressure test, perf_fetch_cnt equals the number of pushes and perf_stall_cnt = 6.
